// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sub_borrow.sv
// Combinational W-bit subtractor (diff = a - b) using per-bit generate/propagate
// borrow terms with lookahead inside each 4-bit group and a ripple between groups.
module sub_borrow #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         bout
);

  localparam int NG = (W + 3) / 4;

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] bin;

  // A bit generates a borrow when a=0,b=1 and passes an incoming borrow when a==b.
  assign g = ~a & b;
  assign p = ~(a ^ b);

  always_comb begin
    logic [NG:0] c;
    logic        t;
    logic        pr;
    int          base;
    int          len;
    c    = '0;
    bin  = '0;
    t    = 1'b0;
    pr   = 1'b0;
    base = 0;
    len  = 0;
    for (int gi = 0; gi < NG; gi++) begin
      base = gi * 4;
      len  = (W - base) < 4 ? (W - base) : 4;
      for (int k = 0; k <= 4; k++) begin
        if (k <= len) begin
          // Sum-of-products lookahead: borrow into position k of this group.
          t = c[gi];
          for (int j = 0; j < 4; j++) begin
            if (j < k) t = t & p[base + j];
          end
          for (int m = 0; m < 4; m++) begin
            if (m < k) begin
              pr = g[base + m];
              for (int j = 0; j < 4; j++) begin
                if (j > m && j < k) pr = pr & p[base + j];
              end
              t = t | pr;
            end
          end
          if (k < len) bin[base + k] = t;
          else         c[gi + 1]     = t;
        end
      end
    end
    bout = c[NG];
  end

  assign diff = a ^ b ^ bin;

endmodule

// File: rtl/div_seq.sv
// Iterative unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, registered quotient/remainder/div_by_zero.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   r_reg;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   t_diff;
  logic             t_bout;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;
  logic             accept;

  // Shift {R,Q} left by one; R is one bit wider so the shift cannot overflow.
  assign r_sh = (r_reg << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};

  sub_borrow #(
    .W (WIDTH + 1)
  ) u_sub (
    .a    (r_sh),
    .b    ({1'b0, d_reg}),
    .diff (t_diff),
    .bout (t_bout)
  );

  assign r_next    = t_bout ? r_sh : t_diff;
  assign q_next    = {q_reg[WIDTH-2:0], ~t_bout};
  assign last_iter = (cnt == LAST);
  assign accept    = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = (divisor == '0) ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      d_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      d_reg <= divisor;
      q_reg <= dividend;
      r_reg <= '0;
      cnt   <= '0;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      q_reg <= q_next;
      r_reg <= r_next;
      cnt   <= cnt + 1'b1;
      // Results are published only on the completing edge.
      if (last_iter) begin
        quotient    <= q_next;
        remainder   <= r_next[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (WIDTH=8) with a short random soak.
module tb_div_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_assert = 0;
  int n_fail   = 0;

  div_seq #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for done; edges counted from the accepting edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int edges, output int busy_cyc);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    busy_cyc = 0;
    tick();
    edges = 1;
    start = 1'b0;
    while (!done && edges < 40) begin
      if (busy) busy_cyc++;
      tick();
      edges++;
    end
  endtask

  initial begin
    int edges;
    int bcyc;
    int seen_done;
    int ndone;
    int cyc;
    int last_cyc;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] eq;
    logic [7:0] er;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);

    run_op(8'd200, 8'd7, edges, bcyc);
    chk("n200_edges", edges, 9);
    chk("n200_busy_cycles", bcyc, 8);
    chk("n200_quot", quotient, 28);
    chk("n200_rem", remainder, 4);
    chk("n200_dbz", div_by_zero, 0);
    chk("n200_busy_in_done", busy, 0);
    tick();
    chk("n200_done_pulse", done, 0);
    chk("n200_quot_held", quotient, 28);

    run_op(8'd255, 8'd1, edges, bcyc);
    chk("e255_1_edges", edges, 9);
    chk("e255_1_quot", quotient, 255);
    chk("e255_1_rem", remainder, 0);

    run_op(8'd5, 8'd9, edges, bcyc);
    chk("e5_9_quot", quotient, 0);
    chk("e5_9_rem", remainder, 5);

    run_op(8'd255, 8'd255, edges, bcyc);
    chk("e255_255_quot", quotient, 1);
    chk("e255_255_rem", remainder, 0);
    tick();

    run_op(8'd77, 8'd0, edges, bcyc);
    chk("dbz_edges", edges, 1);
    chk("dbz_busy_cycles", bcyc, 0);
    chk("dbz_busy", busy, 0);
    chk("dbz_quot", quotient, 255);
    chk("dbz_rem", remainder, 77);
    chk("dbz_flag", div_by_zero, 1);
    tick();
    chk("dbz_done_pulse", done, 0);

    // Restart attempt during CALC must be ignored.
    dividend = 8'd100;
    divisor  = 8'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("rs_held_dbz_in_calc", div_by_zero, 1);
    repeat (4) tick();
    dividend = 8'd9;
    divisor  = 8'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    edges = 6;
    while (!done && edges < 40) begin
      tick();
      edges++;
    end
    chk("rs_edges", edges, 9);
    chk("rs_quot", quotient, 33);
    chk("rs_rem", remainder, 1);
    chk("rs_dbz", div_by_zero, 0);
    repeat (3) tick();
    chk("rs_hold_quot", quotient, 33);
    chk("rs_hold_rem", remainder, 1);
    chk("rs_hold_done", done, 0);

    // Reset during iteration 5 discards the operation.
    dividend = 8'd150;
    divisor  = 8'd10;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_quot", quotient, 0);
    chk("mr_rem", remainder, 0);
    chk("mr_dbz", div_by_zero, 0);
    seen_done = 0;
    repeat (12) begin
      tick();
      if (done || busy) seen_done++;
    end
    chk("mr_no_activity", seen_done, 0);
    run_op(8'd150, 8'd10, edges, bcyc);
    chk("mr_again_edges", edges, 9);
    chk("mr_again_quot", quotient, 15);
    chk("mr_again_rem", remainder, 0);
    tick();

    // rst and start on the same edge: rst wins.
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rs_start_busy", busy, 0);
    chk("rs_start_quot", quotient, 0);
    tick();
    chk("rs_start_busy_after", busy, 0);

    // Back-to-back random operations with start held high.
    ra       = 8'($urandom_range(0, 255));
    rb       = 8'($urandom_range(1, 255));
    eq       = ra / rb;
    er       = ra % rb;
    dividend = ra;
    divisor  = rb;
    start    = 1'b1;
    ndone    = 0;
    cyc      = 0;
    last_cyc = 0;
    while (ndone < 1000 && cyc < 12000) begin
      tick();
      cyc++;
      if (done) begin
        chk("rand_quot", quotient, eq);
        chk("rand_rem", remainder, er);
        if (ndone > 0) chk("rand_spacing", cyc - last_cyc, 9);
        last_cyc = cyc;
        ndone++;
        ra       = 8'($urandom_range(0, 255));
        rb       = 8'($urandom_range(1, 255));
        eq       = ra / rb;
        er       = ra % rb;
        dividend = ra;
        divisor  = rb;
      end
    end
    start = 1'b0;
    chk("rand_count", ndone, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative unsigned restoring divider for the ALU datapath. It computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock, using a trial-subtract borrow chain. It is the subtraction-side counterpart of the carry-lookahead adder. It sits beside the adder in the ALU and is driven by the controller through a start/busy/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE or DONE.
- dividend  in  WIDTH  unsigned dividend; sampled on the accepting edge.
- divisor  in  WIDTH  unsigned divisor; sampled on the accepting edge.
- busy  out  1  high while in CALC.
- done  out  1  one-cycle pulse when results become valid.
- quotient  out  WIDTH  registered result, held until the next completion.
- remainder  out  WIDTH  registered result, held until the next completion.
- div_by_zero  out  1  registered flag, valid with done, held with the results.

## Operation
- States:
  - IDLE: reset state.
  - CALC: iterating, busy=1.
  - DONE: one cycle, done=1.
- Reset values: state=IDLE; busy, done, div_by_zero = 0; quotient, remainder, iteration counter and working registers all 0.
- IDLE/DONE with start=1:
  - Latch divisor into D.
  - Load working quotient Q = dividend and partial remainder R = 0.
  - Clear the counter.
  - If divisor==0, go to DONE directly.
  - Otherwise go to CALC.
- IDLE/DONE with start=0: DONE always returns to IDLE; IDLE stays.
- Each CALC cycle:
  - Shift {R,Q} left by 1.
  - Compute T = R_shifted − D over WIDTH+1 bits in the sub-module.
  - If no borrow: R ← T and Q[0] ← 1. Otherwise R ← R_shifted and Q[0] ← 0.
  - Counter increments.
- On the WIDTH-th CALC iteration:
  - Go to DONE.
  - Copy Q and R into quotient and remainder; div_by_zero ← 0.
- Divide by zero: quotient ← all ones, remainder ← dividend, div_by_zero ← 1; no CALC cycles.
- start during CALC is ignored: no relatch, no restart, no error.
- Outputs quotient, remainder and div_by_zero change only on a completion edge. During CALC they hold the previous result.
- Arithmetic:
  - R is WIDTH+1 bits internally, so the shifted remainder cannot overflow.
  - The result always satisfies dividend = quotient·divisor + remainder and remainder < divisor (divisor ≠ 0).

## Timing
- Latency is measured from the edge that accepts start (edge 0):
  - Normal division: busy=1 after edge 0; iterations on edges 1..WIDTH; done=1 and results valid for the one cycle after edge WIDTH. Latency WIDTH+1 edges, throughput one operation per WIDTH+1 cycles.
  - Divide by zero: done=1 after edge 0, so latency is 1 edge.
- Back-to-back: start held high in the DONE cycle is accepted. The next busy follows immediately with no idle gap, and done is never high for two consecutive cycles from one request.
- rst mid-CALC: on that edge, return to reset values. The partial result is discarded and no done is issued.
- rst and start on the same edge: rst wins; start is ignored.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the default WIDTH;
  - a function computing counter width, $clog2(WIDTH+1).
- Sub-module sub_borrow: a purely combinational (WIDTH+1)-bit subtractor.
  - Inputs: a, b.
  - Outputs: diff and bout (borrow out).
  - Built with generate/propagate borrow lookahead per 4-bit group, mirroring the adder's structure.
- The top module contains only the FSM, counter, shift registers and output registers.

## Test plan
- Normal division: dividend=200, divisor=7, start pulse → busy for 8 cycles, then done pulse with quotient=28, remainder=4, div_by_zero=0; exactly 9 edges from start to done.
- Edge values:
  - 255/1 → quotient=255, remainder=0.
  - 5/9 → quotient=0, remainder=5.
  - 255/255 → quotient=1, remainder=0.
- Divide by zero: 77/0 → done on the next cycle, quotient=255, remainder=77, div_by_zero=1, busy never asserted.
- Ignored restart: start 100/3; re-pulse start with 9/2 at iteration 4 → result is still quotient=33, remainder=1, and results are held afterward.
- Reset mid-operation: assert rst at iteration 5 of 150/10 → next cycle all outputs are 0 and state is IDLE; no done. Then 150/10 → quotient=15, remainder=0.
- Random self-check: 1000 random operand pairs with start held continuously → each done result matches the reference model, with exactly 9-cycle spacing between done pulses.
